// File: rtl/regfile.sv
// Immunity-M0 general-purpose register file: 32 x 32-bit, one WB write port,
// two combinational ID read ports with same-cycle write-back bypass.
module regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int REG_NUM    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  read_en_1,
    input  logic [ADDR_WIDTH-1:0] read_addr_1,
    output logic [DATA_WIDTH-1:0] read_data_1,
    input  logic                  read_en_2,
    input  logic [ADDR_WIDTH-1:0] read_addr_2,
    output logic [DATA_WIDTH-1:0] read_data_2
);

    logic [DATA_WIDTH-1:0] regs [REG_NUM];

    logic wr_live;
    logic hit_1;
    logic hit_2;

    // $0 is never a legal write target, so it also never bypasses
    assign wr_live = write_en && (write_addr != '0);
    assign hit_1   = wr_live && (write_addr == read_addr_1);
    assign hit_2   = wr_live && (write_addr == read_addr_2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[write_addr] <= write_data;
        end
    end

    always_comb begin
        read_data_1 = '0;
        if (rst && read_en_1 && (read_addr_1 != '0)) begin
            if (hit_1) read_data_1 = write_data;
            else       read_data_1 = regs[read_addr_1];
        end
    end

    always_comb begin
        read_data_2 = '0;
        if (rst && read_en_2 && (read_addr_2 != '0)) begin
            if (hit_2) read_data_2 = write_data;
            else       read_data_2 = regs[read_addr_2];
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: behavioural register model compared every
// cycle, plus directed literal expectations.
module tb_regfile;

    logic        clk;
    logic        rst;
    logic        write_en;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic        read_en_1;
    logic [4:0]  read_addr_1;
    logic [31:0] read_data_1;
    logic        read_en_2;
    logic [4:0]  read_addr_2;
    logic [31:0] read_data_2;

    int tests;
    int fails;

    logic [31:0] mdl [32];

    regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .REG_NUM(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .write_en   (write_en),
        .write_addr (write_addr),
        .write_data (write_data),
        .read_en_1  (read_en_1),
        .read_addr_1(read_addr_1),
        .read_data_1(read_data_1),
        .read_en_2  (read_en_2),
        .read_addr_2(read_addr_2),
        .read_data_2(read_data_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Architectural model: register contents as the programmer sees them
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        end else if (write_en && write_addr != 5'd0) begin
            mdl[write_addr] = write_data;
        end
    end

    function automatic logic [31:0] expect_read(input logic en,
                                                input logic [4:0] a);
        if (!rst || !en || a == 5'd0) return 32'h0;
        if (write_en && write_addr == a) return write_data;
        return mdl[a];
    endfunction

    always @(negedge clk) begin
        check("model_rd1", read_data_1, expect_read(read_en_1, read_addr_1));
        check("model_rd2", read_data_2, expect_read(read_en_2, read_addr_2));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        write_en   = 1'b1;
        write_addr = a;
        write_data = d;
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
        read_en_1   = 1'b1;
        read_en_2   = 1'b1;
        read_addr_1 = a1;
        read_addr_2 = a2;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b0;
        write_en = 1'b1;
        write_addr = 5'd4;
        write_data = 32'hCAFE_F00D;
        rd(5'd4, 5'd9);

        // Reset held for 3 cycles even with a write presented
        repeat (3) begin
            @(negedge clk);
            check("rst_hold_rd1", read_data_1, 32'h0);
            check("rst_hold_rd2", read_data_2, 32'h0);
        end
        step();
        rst = 1'b1;
        write_en = 1'b0;

        for (int i = 0; i < 32; i++) begin
            rd(5'(i), 5'(31 - i));
            #2;
            check("post_rst_rd1", read_data_1, 32'h0);
            check("post_rst_rd2", read_data_2, 32'h0);
            step();
        end

        // Write then read
        wr(5'd5, 32'hDEAD_BEEF);
        step();
        write_en = 1'b0;
        rd(5'd5, 5'd5);
        #2;
        check("wr_rd_p1", read_data_1, 32'hDEAD_BEEF);
        check("wr_rd_p2", read_data_2, 32'hDEAD_BEEF);
        step();

        // Same-cycle bypass
        wr(5'd7, 32'h1111_1111);
        step();
        wr(5'd7, 32'h2222_2222);
        rd(5'd7, 5'd5);
        #2;
        check("bypass_p1", read_data_1, 32'h2222_2222);
        check("no_bypass_p2", read_data_2, 32'hDEAD_BEEF);
        step();
        write_en = 1'b0;
        rd(5'd7, 5'd7);
        #2;
        check("bypass_landed", read_data_1, 32'h2222_2222);
        step();

        // Both ports bypassing together
        wr(5'd12, 32'h0BAD_CAFE);
        rd(5'd12, 5'd12);
        #2;
        check("dual_bypass_p1", read_data_1, 32'h0BAD_CAFE);
        check("dual_bypass_p2", read_data_2, 32'h0BAD_CAFE);
        step();

        // $0 protection
        wr(5'd0, 32'hFFFF_FFFF);
        rd(5'd0, 5'd0);
        #2;
        check("r0_bypass_p2", read_data_2, 32'h0);
        check("r0_bypass_p1", read_data_1, 32'h0);
        step();
        write_en = 1'b0;
        #2;
        check("r0_after_p2", read_data_2, 32'h0);
        step();

        // Read-enable gating
        wr(5'd3, 32'h1234_5678);
        step();
        write_en = 1'b0;
        rd(5'd3, 5'd3);
        read_en_1 = 1'b0;
        #2;
        check("en_gate_off", read_data_1, 32'h0);
        check("en_gate_other", read_data_2, 32'h1234_5678);
        read_en_1 = 1'b1;
        #1;
        check("en_gate_on", read_data_1, 32'h1234_5678);
        step();

        // Back-to-back writes to one index: last wins
        wr(5'd10, 32'h0000_0001);
        rd(5'd10, 5'd3);
        #2;
        check("b2b_first", read_data_1, 32'h0000_0001);
        step();
        wr(5'd10, 32'h0000_0002);
        #2;
        check("b2b_second", read_data_1, 32'h0000_0002);
        step();
        write_en = 1'b0;
        #2;
        check("b2b_final", read_data_1, 32'h0000_0002);
        step();

        // Fill r1..r31 with their index
        for (int i = 1; i < 32; i++) begin
            wr(5'(i), 32'(i));
            rd(5'(i), 5'(i - 1));
            step();
        end
        write_en = 1'b0;
        rd(5'd31, 5'd17);
        #2;
        check("fill_r31", read_data_1, 32'd31);
        check("fill_r17", read_data_2, 32'd17);
        step();

        // Asynchronous reset between edges while a write is presented
        wr(5'd9, 32'h0000_ABCD);
        rd(5'd9, 5'd1);
        #2;
        check("pre_rst_bypass", read_data_1, 32'h0000_ABCD);
        check("pre_rst_r1", read_data_2, 32'd1);
        rst = 1'b0;
        #1;
        check("async_rst_rd1", read_data_1, 32'h0);
        check("async_rst_rd2", read_data_2, 32'h0);
        step();
        rst = 1'b1;
        write_en = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), 5'(i));
            #2;
            check("after_rst_rd1", read_data_1, 32'h0);
            check("after_rst_rd2", read_data_2, 32'h0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile.md
# regfile

General-purpose register file for the Immunity-M0 MIPS core, and the receiving end of the write-back interface driven by the WB stage. The block holds 32 × 32-bit architectural registers and accepts one write per cycle from WB. It serves two independent combinational read ports to the ID stage. Writes land on the rising clock edge, and a same-cycle WB→ID bypass resolves the read-after-write hazard. Register `$0` reads as zero permanently.

## Interface
Parameters:
- `DATA_WIDTH`, 32, register and result width (matches `DATA_BUS`)
- `ADDR_WIDTH`, 5, register index width (matches `REG_ADDR_BUS`)
- `REG_NUM`, 32, number of architectural registers (2^ADDR_WIDTH)

Ports:
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `write_en` input, 1 bit: write strobe from WB (`write_reg_en_out`).
- `write_addr` input, ADDR_WIDTH bits: destination index from WB.
- `write_data` input, DATA_WIDTH bits: result from WB.
- `read_en_1` input, 1 bit: port-1 read enable from ID.
- `read_addr_1` input, ADDR_WIDTH bits: port-1 index.
- `read_data_1` output, DATA_WIDTH bits: port-1 data, combinational.
- `read_en_2` input, 1 bit: port-2 read enable.
- `read_addr_2` input, ADDR_WIDTH bits: port-2 index.
- `read_data_2` output, DATA_WIDTH bits: port-2 data, combinational.

## Operation
- Storage is an array `regs[0..REG_NUM-1]` of DATA_WIDTH bits.
- Reset:
  - While `rst` = 0, every entry is cleared to 0 asynchronously, and both read outputs are forced to 0.
  - No write is accepted while in reset.
- Write:
  - On a rising edge with `rst` = 1, `write_en` = 1 and `write_addr` ≠ 0, `regs[write_addr]` ← `write_data`.
  - A write to index 0 is discarded silently, and `regs[0]` stays 0.
- Read (applies to each port independently; port 2 is identical to port 1):
  - If `rst` = 0, `read_data_1` = 0.
  - Else if `read_en_1` = 0, `read_data_1` = 0.
  - Else if `read_addr_1` = 0, `read_data_1` = 0.
  - Else if `write_en` = 1 and `write_addr` = `read_addr_1`, `read_data_1` = `write_data` (bypass).
  - Else `read_data_1` = `regs[read_addr_1]`.
- Both ports may read the same index, and both may bypass in the same cycle.
- A read never alters state.
- There is no X propagation from unused indices, because all entries are initialised by reset.

## Timing
- Write latency: a write is architecturally visible in `regs` one rising edge after it is presented. Through the bypass, it is visible on the read ports in the same cycle, with zero latency.
- Read path: purely combinational from the addresses, enables, write-port signals and `regs`. There is no registered output stage.
- Reset:
  - Assertion clears the array and outputs immediately, with no clock required.
  - Deassertion is sampled on the next rising edge. The first write can land on the first edge where `rst` = 1.
- Reset asserted mid-write (in the same cycle as `write_en` = 1): the write is lost and the entry reads 0.
- Back-to-back writes to the same index on consecutive edges: the last write wins. In each cycle, the bypass returns the write currently being presented.
- `write_en` = 1 with `write_addr` = 0 and `read_addr_1` = 0: the read returns 0. The bypass must not leak `write_data` into `$0`.

## Test plan
- Reset check:
  - Stimulus: hold `rst` = 0 for 3 cycles, then release, then read indices 0–31 on both ports with enables = 1.
  - Required response: all reads return `0x00000000`.
- Write then read:
  - Stimulus: write `0xDEADBEEF` to r5, then on the next cycle read r5 on port 1 and r5 on port 2, with `write_en` = 0.
  - Required response: both ports return `0xDEADBEEF`.
- Same-cycle bypass:
  - Stimulus: r7 holds `0x11111111`; present a write of `0x22222222` to r7 while `read_addr_1` = 7.
  - Required response: `read_data_1` = `0x22222222` in that cycle, and r7 holds `0x22222222` afterwards.
- `$0` protection:
  - Stimulus: write `0xFFFFFFFF` to r0 while `read_addr_2` = 0, then read r0 again next cycle.
  - Required response: port 2 returns 0 in both cycles.
- Read enable gating:
  - Stimulus: r3 = `0x12345678`, `read_en_1` = 0, `read_addr_1` = 3.
  - Required response: `read_data_1` = 0.
  - Follow-up: raise `read_en_1`; `read_data_1` = `0x12345678`.
- Asynchronous reset mid-operation:
  - Stimulus: fill r1–r31 with their index values, then assert `rst` = 0 between clock edges while `write_en` = 1.
  - Required response: outputs drop to 0 before the next edge. After release, every register reads 0.
